stage_sequencer: RTL and testbench

Generates the 3-bit `Stage` code (0 = idle, 1–5 = Fetch/Decode/Execute/Memory/WriteBack) that drives the control-signal enable decoder of the multicycle processor. It adds run/single-step control, NOP stage skipping, HALT handling and a bounded memory-stage wait with timeout. It also counts retired instructions. It sits between the front-panel/debug controls, the instruction decoder and the enable decoder.

---
 rtl/stage_sequencer_if.sv | 25 ++
 rtl/stage_sequencer.sv | 83 ++++++++
 tb/tb_stage_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the front panel, instruction decoder and the stage sequencer.
interface stage_sequencer_if;
  logic        Run;
  logic        Step;
  logic        NOP_FLAG;
  logic        Halt_Instr;
  logic        Mem_Access_Stage4;
  logic        Mem_Ready;
  logic [2:0]  Stage;
  logic        Busy;
  logic        Stall;
  logic        Halted;
  logic        Mem_Timeout;
  logic [15:0] Instr_Count;

  modport master (
    output Run, Step, NOP_FLAG, Halt_Instr, Mem_Access_Stage4, Mem_Ready,
    input  Stage, Busy, Stall, Halted, Mem_Timeout, Instr_Count
  );

  modport slave (
    input  Run, Step, NOP_FLAG, Halt_Instr, Mem_Access_Stage4, Mem_Ready,
    output Stage, Busy, Stall, Halted, Mem_Timeout, Instr_Count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: run/step control, NOP skip, HALT, bounded memory wait
// with timeout, and a retired-instruction counter.
module stage_sequencer #(
  parameter int MEM_WAIT_MAX = 8,
  parameter int WAIT_W       = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  stage_sequencer_if.slave sig
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    HALT = 3'd6
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [2:0]        stage_q;
  logic              halted_q, timeout_q, timeout_set;
  logic [15:0]       cnt_q;
  logic [WAIT_W-1:0] wait_q;

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: if (sig.Run || sig.Step) state_d = S1;
      S1:   state_d = S2;
      S2: begin
        if (sig.Halt_Instr)    state_d = HALT;
        else if (sig.NOP_FLAG) state_d = S5;
        else                   state_d = S3;
      end
      S3:   state_d = S4;
      S4: begin
        if (!sig.Mem_Access_Stage4 || sig.Mem_Ready) begin
          state_d = S5;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = HALT;
          timeout_set = 1'b1;
        end
      end
      S5:   state_d = sig.Run ? S1 : IDLE;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      stage_q   <= 3'd0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 16'd0;
      wait_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= (state_d == HALT) ? 3'd0 : state_d;
      if (state_d == HALT) halted_q  <= 1'b1;
      if (timeout_set)     timeout_q <= 1'b1;
      if (state_q == S5)   cnt_q     <= cnt_q + 16'd1;
      // Counter only advances while parked in S4, so any fresh entry starts at zero.
      if (state_q == S4 && state_d == S4) wait_q <= wait_q + 1'b1;
      else                                wait_q <= '0;
    end
  end

  assign sig.Stage       = stage_q;
  assign sig.Busy        = (stage_q != 3'd0);
  assign sig.Stall       = (stage_q == 3'd4) && sig.Mem_Access_Stage4 && !sig.Mem_Ready;
  assign sig.Halted      = halted_q;
  assign sig.Mem_Timeout = timeout_q;
  assign sig.Instr_Count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: expected Stage codes are queued per scenario
// and popped one per clock.
module tb_stage_sequencer;
  logic Clock = 1'b0;
  logic Reset_n = 1'b0;

  stage_sequencer_if sig();

  stage_sequencer #(.MEM_WAIT_MAX(8), .WAIT_W(4)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .sig     (sig)
  );

  always #5 Clock = ~Clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  exp_q[$];
  logic [15:0] exp_cnt;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    sig.Run = 0; sig.Step = 0; sig.NOP_FLAG = 0; sig.Halt_Instr = 0;
    sig.Mem_Access_Stage4 = 0; sig.Mem_Ready = 0;
  endtask

  task automatic do_reset();
    Reset_n = 0;
    idle_inputs();
    exp_cnt = 16'd0;
    exp_q.delete();
    tick();
    Reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset_n = 0;
    #12;
    n_tests++;
    if (sig.Stage !== 3'd0) begin n_fail++; $display("FAIL reset_stage: got %0d expected 0", sig.Stage); end
    n_tests++;
    if ({sig.Busy, sig.Stall, sig.Halted, sig.Mem_Timeout} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {sig.Busy, sig.Stall, sig.Halted, sig.Mem_Timeout});
    end
    n_tests++;
    if (sig.Instr_Count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", sig.Instr_Count); end
    tick();
    Reset_n = 1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_run();
    logic [2:0] e;
    for (int r = 0; r < 3; r++)
      for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    exp_q.push_back(3'd0);
    sig.Run = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) sig.Run = 0;
      e = exp_q.pop_front();
      n_tests++;
      if (sig.Stage !== e) begin n_fail++; $display("FAIL run_stage[%0d]: got %0d expected %0d", i, sig.Stage, e); end
    end
    exp_cnt = exp_cnt + 16'd3;
    n_tests++;
    if (sig.Instr_Count !== exp_cnt) begin n_fail++; $display("FAIL run_count: got %0d expected %0d", sig.Instr_Count, exp_cnt); end
  endtask

  task automatic test_step();
    logic [2:0] e;
    for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    sig.Step = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      sig.Step = (i == 2);  // second pulse lands while in S3
      e = exp_q.pop_front();
      n_tests++;
      if (sig.Stage !== e) begin n_fail++; $display("FAIL step_stage[%0d]: got %0d expected %0d", i, sig.Stage, e); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if (sig.Instr_Count !== exp_cnt) begin n_fail++; $display("FAIL step_count: got %0d expected %0d", sig.Instr_Count, exp_cnt); end
    n_tests++;
    if (sig.Busy !== 1'b0) begin n_fail++; $display("FAIL step_busy: got %b expected 0", sig.Busy); end
  endtask

  task automatic test_nop();
    logic [2:0] e;
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd5);
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd5);
    exp_q.push_back(3'd0);
    sig.NOP_FLAG = 1;
    sig.Run = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 3) sig.Run = 0;
      e = exp_q.pop_front();
      n_tests++;
      if (sig.Stage !== e) begin n_fail++; $display("FAIL nop_stage[%0d]: got %0d expected %0d", i, sig.Stage, e); end
    end
    sig.NOP_FLAG = 0;
    exp_cnt = exp_cnt + 16'd2;
    n_tests++;
    if (sig.Instr_Count !== exp_cnt) begin n_fail++; $display("FAIL nop_count: got %0d expected %0d", sig.Instr_Count, exp_cnt); end
  endtask

  task automatic test_mem_wait(input int k);
    logic [2:0] e;
    logic       exp_stall;
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    for (int j = 0; j < k; j++) exp_q.push_back(3'd4);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd0);
    sig.Mem_Access_Stage4 = 1;
    sig.Mem_Ready = 0;
    sig.Run = 1;
    for (int i = 0; i < k + 5; i++) begin
      tick();
      if (i == 0) sig.Run = 0;
      e = exp_q.pop_front();
      n_tests++;
      if (sig.Stage !== e) begin n_fail++; $display("FAIL memwait%0d_stage[%0d]: got %0d expected %0d", k, i, sig.Stage, e); end
      if (i >= 3 && i < 3 + k) begin
        if (i == 2 + k) sig.Mem_Ready = 1;
        exp_stall = (i != 2 + k);
        #1;
        n_tests++;
        if (sig.Stall !== exp_stall) begin n_fail++; $display("FAIL memwait%0d_stall[%0d]: got %b expected %b", k, i, sig.Stall, exp_stall); end
      end else begin
        sig.Mem_Ready = 0;
      end
    end
    sig.Mem_Access_Stage4 = 0;
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if (sig.Instr_Count !== exp_cnt) begin n_fail++; $display("FAIL memwait%0d_count: got %0d expected %0d", k, sig.Instr_Count, exp_cnt); end
  endtask

  task automatic test_timeout();
    logic [2:0] e;
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    for (int j = 0; j < 8; j++) exp_q.push_back(3'd4);
    for (int j = 0; j < 5; j++) exp_q.push_back(3'd0);
    sig.Mem_Access_Stage4 = 1;
    sig.Mem_Ready = 0;
    sig.Run = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      sig.Step = (i == 12);
      e = exp_q.pop_front();
      n_tests++;
      if (sig.Stage !== e) begin n_fail++; $display("FAIL timeout_stage[%0d]: got %0d expected %0d", i, sig.Stage, e); end
    end
    n_tests++;
    if ({sig.Halted, sig.Mem_Timeout, sig.Busy} !== 3'b110) begin
      n_fail++; $display("FAIL timeout_flags: got %b expected 110", {sig.Halted, sig.Mem_Timeout, sig.Busy});
    end
    n_tests++;
    if (sig.Instr_Count !== exp_cnt) begin n_fail++; $display("FAIL timeout_count: got %0d expected %0d", sig.Instr_Count, exp_cnt); end
    do_reset();
  endtask

  task automatic test_halt();
    logic [2:0] e;
    for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    sig.Run = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) begin sig.Halt_Instr = 1; sig.NOP_FLAG = 1; end
      e = exp_q.pop_front();
      n_tests++;
      if (sig.Stage !== e) begin n_fail++; $display("FAIL halt_stage[%0d]: got %0d expected %0d", i, sig.Stage, e); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if ({sig.Halted, sig.Mem_Timeout} !== 2'b10) begin
      n_fail++; $display("FAIL halt_flags: got %b expected 10", {sig.Halted, sig.Mem_Timeout});
    end
    n_tests++;
    if (sig.Instr_Count !== exp_cnt) begin n_fail++; $display("FAIL halt_count: got %0d expected %0d", sig.Instr_Count, exp_cnt); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    sig.Run = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (sig.Stage !== e) begin n_fail++; $display("FAIL rstmid_stage[%0d]: got %0d expected %0d", i, sig.Stage, e); end
    end
    n_tests++;
    if (sig.Instr_Count !== 16'd1) begin n_fail++; $display("FAIL rstmid_precount: got %0d expected 1", sig.Instr_Count); end
    #2;
    Reset_n = 0;
    #1;
    n_tests++;
    if ({sig.Stage, sig.Busy, sig.Stall, sig.Halted, sig.Mem_Timeout} !== 7'd0 || sig.Instr_Count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got stage=%0d busy=%b stall=%b halted=%b timeout=%b count=%0d expected all 0",
               sig.Stage, sig.Busy, sig.Stall, sig.Halted, sig.Mem_Timeout, sig.Instr_Count);
    end
    idle_inputs();
    tick();
    Reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_nop();
    test_mem_wait(1);
    test_mem_wait(3);
    test_mem_wait(8);
    test_timeout();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
